// File: rtl/srio_pkg.sv
// Shared SRIO SWRITE definitions: header field positions, FTYPE code, status bits
// and the unpacker state encoding. The packer imports the same package.
package srio_pkg;

  localparam logic [3:0] FTYPE_SWRITE    = 4'b0110;
  localparam int         HDR_FTYPE_LSB   = 52;
  localparam int         HDR_PRIO_LSB    = 45;
  localparam int         HDR_CRF_BIT     = 44;
  localparam int         HDR_ADDR_LSB    = 0;
  localparam int         MAX_PAYLOAD_DEF = 32;

  localparam int ST_TYPE_ERR     = 0;
  localparam int ST_OVERSIZE_ERR = 1;
  localparam int ST_RUNT_ERR     = 2;
  localparam int ST_ADDR_ERR     = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_DROP
  } unpack_state_t;

  function automatic logic [3:0] hdr_ftype(input logic [63:0] hdr);
    return hdr[HDR_FTYPE_LSB +: 4];
  endfunction

  function automatic logic [31:0] hdr_addr(input logic [63:0] hdr);
    return hdr[HDR_ADDR_LSB +: 32];
  endfunction

endpackage

// File: rtl/srio_swrite_unpack_logic_if.sv
// Stream bundle of the SWRITE unpacker: SRIO-side input stream and payload output stream.
// master = stream source / payload sink (SRIO endpoint side), slave = the unpacker.
interface srio_swrite_unpack_logic_if;
  import srio_pkg::*;

  logic        S_AXIS_TVALID;
  logic        S_AXIS_TREADY;
  logic        S_AXIS_TLAST;
  logic [63:0] S_AXIS_TDATA;
  logic [31:0] S_AXIS_TUSER;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic        M_AXIS_TLAST;
  logic [63:0] M_AXIS_TDATA;

  modport master (
    output S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TDATA, S_AXIS_TUSER, M_AXIS_TREADY,
    input  S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA
  );

  modport slave (
    input  S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TDATA, S_AXIS_TUSER, M_AXIS_TREADY,
    output S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA
  );

endinterface

// File: rtl/axis_out_reg.sv
// One-deep ready/valid output register; accepts a new word whenever empty or draining.
module axis_out_reg
  import srio_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              drain,
  output logic              accept,
  output logic              vld_p1,
  output logic [DATA_W-1:0] data_p1,
  output logic              last_p1
);

  assign accept = !vld_p1 || drain;

  // stage p1: output word held until the downstream handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (clr) begin
      vld_p1  <= 1'b0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= load_data;
      last_p1 <= load_last;
    end else if (drain) begin
      vld_p1  <= 1'b0;
    end
  end

endmodule

// File: rtl/srio_swrite_unpack_logic.sv
// SRIO SWRITE receive unpacker: checks/strips the header and forwards the payload.
// Optional expected-address check enabled by defining SRIO_SWRITE_UNPACK_ADDR_CHECK_EN.
module srio_swrite_unpack_logic
  import srio_pkg::*;
#(
  parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEF
) (
  input  logic                        AXIS_ACLK,
  input  logic                        AXIS_ARESET,
  srio_swrite_unpack_logic_if.slave   axis,
  input  logic [31:0]                 cmd,
  output logic [31:0]                 last_addr,
  output logic [31:0]                 last_srcdest,
  output logic [15:0]                 pkt_cnt,
  output logic [3:0]                  status
);

  localparam logic [5:0] CNT_MAX = 6'(MAX_PAYLOAD - 1);

  unpack_state_t state, state_nxt;
  logic [5:0]    count;
  logic [2:0]    err_sticky;
  logic          enable, flush, at_max, out_accept;
  logic          s_ready, load, load_last;
  logic          hdr_good, hdr_bad, hdr_runt, pkt_done, oversize;
  logic          unused_cmd;

  assign enable     = cmd[0];
  assign flush      = cmd[1];
  assign unused_cmd = &{1'b0, cmd[31:2]};
  assign at_max     = (count == CNT_MAX);

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) state <= S_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    load      = 1'b0;
    load_last = 1'b0;
    hdr_good  = 1'b0;
    hdr_bad   = 1'b0;
    hdr_runt  = 1'b0;
    pkt_done  = 1'b0;
    oversize  = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) state_nxt = S_HDR;
      end
      S_HDR: begin
        // disable takes effect only between packets
        if (!enable) begin
          state_nxt = S_IDLE;
        end else begin
          s_ready = 1'b1;
          if (axis.S_AXIS_TVALID) begin
            if (hdr_ftype(axis.S_AXIS_TDATA) != FTYPE_SWRITE) begin
              hdr_bad = 1'b1;
              if (!axis.S_AXIS_TLAST) state_nxt = S_DROP;
            end else if (axis.S_AXIS_TLAST) begin
              hdr_runt = 1'b1;
            end else begin
              hdr_good  = 1'b1;
              state_nxt = S_PAYLOAD;
            end
          end
        end
      end
      S_PAYLOAD: begin
        s_ready = out_accept;
        if (axis.S_AXIS_TVALID && out_accept) begin
          load      = 1'b1;
          load_last = axis.S_AXIS_TLAST || at_max;
          if (axis.S_AXIS_TLAST) begin
            pkt_done  = 1'b1;
            state_nxt = S_HDR;
          end else if (at_max) begin
            oversize  = 1'b1;
            state_nxt = S_DROP;
          end
        end
      end
      S_DROP: begin
        s_ready = 1'b1;
        if (axis.S_AXIS_TVALID && axis.S_AXIS_TLAST) state_nxt = S_HDR;
      end
      default: state_nxt = S_IDLE;
    endcase
    // flush overrides everything; a beat in the same cycle is discarded
    if (flush) begin
      state_nxt = S_IDLE;
      load      = 1'b0;
    end
  end

  assign axis.S_AXIS_TREADY = s_ready;

  axis_out_reg #(.DATA_W(64)) u_out (
    .clk       (AXIS_ACLK),
    .rst       (AXIS_ARESET),
    .clr       (flush),
    .load      (load),
    .load_data (axis.S_AXIS_TDATA),
    .load_last (load_last),
    .drain     (axis.M_AXIS_TREADY),
    .accept    (out_accept),
    .vld_p1    (axis.M_AXIS_TVALID),
    .data_p1   (axis.M_AXIS_TDATA),
    .last_p1   (axis.M_AXIS_TLAST)
  );

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      count        <= '0;
      pkt_cnt      <= '0;
      err_sticky   <= '0;
      last_addr    <= '0;
      last_srcdest <= '0;
    end else if (flush) begin
      count      <= '0;
      pkt_cnt    <= '0;
      err_sticky <= '0;
    end else begin
      if (hdr_good) begin
        last_addr    <= hdr_addr(axis.S_AXIS_TDATA);
        last_srcdest <= axis.S_AXIS_TUSER;
        count        <= '0;
      end
      if (load && !pkt_done && !oversize) count <= count + 6'd1;
      if (pkt_done) pkt_cnt <= pkt_cnt + 16'd1;
      if (hdr_bad)  err_sticky[ST_TYPE_ERR]     <= 1'b1;
      if (oversize) err_sticky[ST_OVERSIZE_ERR] <= 1'b1;
      if (hdr_runt) err_sticky[ST_RUNT_ERR]     <= 1'b1;
    end
  end

`ifdef SRIO_SWRITE_UNPACK_ADDR_CHECK_EN
  logic [31:0] exp_addr;
  logic        exp_vld;
  logic        addr_err;

  // expected address resyncs on every good header, advances 8 bytes per payload word
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      exp_addr <= '0;
      exp_vld  <= 1'b0;
      addr_err <= 1'b0;
    end else if (flush) begin
      exp_vld  <= 1'b0;
      addr_err <= 1'b0;
    end else if (hdr_good) begin
      if (exp_vld && (hdr_addr(axis.S_AXIS_TDATA) != exp_addr)) addr_err <= 1'b1;
      exp_addr <= hdr_addr(axis.S_AXIS_TDATA);
      exp_vld  <= 1'b1;
    end else if (pkt_done) begin
      exp_addr <= exp_addr + {23'd0, count + 6'd1, 3'b000};
    end
  end

  assign status = {addr_err, err_sticky};
`else
  assign status = {1'b0, err_sticky};
`endif

endmodule

// File: tb/tb_srio_swrite_unpack_logic.sv
// Scoreboard bench for srio_swrite_unpack_logic: directed packets, expected words queued.
module tb_srio_swrite_unpack_logic;
  import srio_pkg::*;

`ifdef SRIO_SWRITE_UNPACK_ADDR_CHECK_EN
  localparam logic AE = 1'b1;
`else
  localparam logic AE = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] cmd;
  logic [31:0] last_addr;
  logic [31:0] last_srcdest;
  logic [15:0] pkt_cnt;
  logic [3:0]  status;

  srio_swrite_unpack_logic_if bus();

  srio_swrite_unpack_logic dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESET  (rst),
    .axis         (bus),
    .cmd          (cmd),
    .last_addr    (last_addr),
    .last_srcdest (last_srcdest),
    .pkt_cnt      (pkt_cnt),
    .status       (status)
  );

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } beat_t;

  beat_t      exp_q[$];
  int         nvec = 0;
  int         nerr = 0;
  logic       rand_rdy = 1'b0;
  logic       stall_prev = 1'b0;
  logic [64:0] prev_out = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input logic [3:0] ft, input logic [31:0] addr);
    return {8'h00, ft, 5'h00, 2'b10, 1'b1, 12'h000, addr};
  endfunction

  task automatic push_words(input logic [63:0] base, input int n, input logic last);
    for (int i = 0; i < n; i++)
      exp_q.push_back({last && (i == n - 1), base + 64'(i)});
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l, input logic [31:0] u,
                           output int stalls);
    bus.S_AXIS_TVALID = 1'b1;
    bus.S_AXIS_TDATA  = d;
    bus.S_AXIS_TLAST  = l;
    bus.S_AXIS_TUSER  = u;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (bus.S_AXIS_TREADY) break;
      stalls++;
      if (stalls > 500) begin
        nvec++;
        nerr++;
        $display("FAIL beat_accept: TREADY low for %0d cycles, expected handshake", stalls);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.S_AXIS_TVALID = 1'b0;
    bus.S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic send_pkt(input logic [63:0] hdr, input logic [31:0] user, input int n,
                          input logic [63:0] base, output int total);
    int s;
    send_beat(hdr, n == 0, user, s);
    total = s;
    for (int i = 0; i < n; i++) begin
      send_beat(base + 64'(i), i == n - 1, user, s);
      total += s;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.M_AXIS_TVALID) break;
    end
    chk("drain_remaining", 65'(exp_q.size()), 65'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    cmd = 32'h2;
    repeat (2) @(posedge clk);
    #1;
    cmd = 32'h1;
  endtask

  // Ready generator: always ready unless random backpressure is requested
  initial begin
    bus.M_AXIS_TREADY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.M_AXIS_TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output handshake
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && stall_prev && bus.M_AXIS_TVALID)
        chk("out_hold", {bus.M_AXIS_TLAST, bus.M_AXIS_TDATA}, prev_out);
      if (!rst && bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL out_unexpected: got word 0x%0h, expected no output", bus.M_AXIS_TDATA);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("out_data", 65'(bus.M_AXIS_TDATA), 65'(e.data));
          chk("out_last", 65'(bus.M_AXIS_TLAST), 65'(e.last));
        end
      end
      stall_prev = bus.M_AXIS_TVALID && !bus.M_AXIS_TREADY;
      prev_out   = {bus.M_AXIS_TLAST, bus.M_AXIS_TDATA};
    end
  end

  initial begin
    int st;
    rst = 1'b1;
    cmd = 32'h0;
    bus.S_AXIS_TVALID = 1'b0;
    bus.S_AXIS_TLAST  = 1'b0;
    bus.S_AXIS_TDATA  = '0;
    bus.S_AXIS_TUSER  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_m_tvalid", 65'(bus.M_AXIS_TVALID), 65'd0);
    chk("rst_m_tlast", 65'(bus.M_AXIS_TLAST), 65'd0);
    chk("rst_m_tdata", 65'(bus.M_AXIS_TDATA), 65'd0);
    chk("rst_s_tready", 65'(bus.S_AXIS_TREADY), 65'd0);
    chk("rst_last_addr", 65'(last_addr), 65'd0);
    chk("rst_last_srcdest", 65'(last_srcdest), 65'd0);
    chk("rst_pkt_cnt", 65'(pkt_cnt), 65'd0);
    chk("rst_status", 65'(status), 65'd0);

    @(posedge clk);
    #1;
    cmd = 32'h1;
    @(posedge clk);
    #1;

    // basic 4-word packet
    push_words(64'hA000_0000_0000_0000, 4, 1'b1);
    send_pkt(mk_hdr(4'h6, 32'h1000_0000), 32'h0001_0002, 4, 64'hA000_0000_0000_0000, st);
    wait_drain();
    chk("t1_last_addr", 65'(last_addr), 65'h1000_0000);
    chk("t1_last_srcdest", 65'(last_srcdest), 65'h0001_0002);
    chk("t1_pkt_cnt", 65'(pkt_cnt), 65'd1);
    chk("t1_status", 65'(status), 65'd0);

    // wrong ftype is dropped, then a good packet flows
    send_pkt(mk_hdr(4'h5, 32'h1234_5678), 32'hDEAD_BEEF, 3, 64'hB000_0000_0000_0000, st);
    wait_drain();
    chk("t2_status_type", 65'(status), 65'h1);
    push_words(64'hC000_0000_0000_0000, 2, 1'b1);
    send_pkt(mk_hdr(4'h6, 32'h1000_0020), 32'h0003_0004, 2, 64'hC000_0000_0000_0000, st);
    wait_drain();
    chk("t2_pkt_cnt", 65'(pkt_cnt), 65'd2);
    chk("t2_last_addr", 65'(last_addr), 65'h1000_0020);

    // oversize: 40 words in, 32 out with forced TLAST
    push_words(64'hD000_0000_0000_0000, 32, 1'b1);
    send_pkt(mk_hdr(4'h6, 32'h1000_0030), 32'h0005_0006, 40, 64'hD000_0000_0000_0000, st);
    wait_drain();
    chk("t3_status", 65'(status), 65'h3);
    chk("t3_pkt_cnt", 65'(pkt_cnt), 65'd2);

    // runt: header carries TLAST
    send_beat(mk_hdr(4'h6, 32'h5555_0000), 1'b1, 32'h0000_0009, st);
    wait_drain();
    chk("t4_status", 65'(status), 65'h7);
    chk("t4_last_addr", 65'(last_addr), 65'h1000_0030);
    chk("t4_last_srcdest", 65'(last_srcdest), 65'h0005_0006);

    // full-length packet under random backpressure
    rand_rdy = 1'b1;
    push_words(64'hE000_0000_0000_0000, 32, 1'b1);
    send_pkt(mk_hdr(4'h6, 32'h1000_0030), 32'h0007_0008, 32, 64'hE000_0000_0000_0000, st);
    wait_drain();
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_pkt_cnt", 65'(pkt_cnt), 65'd3);
    chk("t5_status", 65'(status), 65'h7);

    // full rate with downstream always ready
    push_words(64'hF000_0000_0000_0000, 8, 1'b1);
    send_pkt(mk_hdr(4'h6, 32'h1000_0130), 32'h0009_000A, 8, 64'hF000_0000_0000_0000, st);
    chk("t6_full_rate_stalls", 65'(st), 65'd0);
    wait_drain();
    chk("t6_pkt_cnt", 65'(pkt_cnt), 65'd4);

    // disable between packets returns to IDLE
    cmd = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t7_idle_tready", 65'(bus.S_AXIS_TREADY), 65'd0);
    @(posedge clk);
    #1;
    cmd = 32'h1;
    @(posedge clk);
    #1;

    // flush mid-packet after 10 words
    push_words(64'h1100_0000_0000_0000, 10, 1'b0);
    send_beat(mk_hdr(4'h6, 32'h1000_0170), 32'h000B_000C, 1'b0, st);
    for (int i = 0; i < 10; i++)
      send_beat(64'h1100_0000_0000_0000 + 64'(i), 1'b0, 32'h000B_000C, st);
    cmd = 32'h2;
    @(posedge clk);
    @(negedge clk);
    chk("t8_flush_tvalid", 65'(bus.M_AXIS_TVALID), 65'd0);
    chk("t8_flush_status", 65'(status), 65'd0);
    chk("t8_flush_pkt_cnt", 65'(pkt_cnt), 65'd0);
    @(posedge clk);
    #1;
    cmd = 32'h1;
    push_words(64'h2200_0000_0000_0000, 3, 1'b1);
    send_pkt(mk_hdr(4'h6, 32'h0000_2000), 32'h000D_000E, 3, 64'h2200_0000_0000_0000, st);
    wait_drain();
    chk("t8_last_addr", 65'(last_addr), 65'h0000_2000);
    chk("t8_pkt_cnt", 65'(pkt_cnt), 65'd1);
    chk("t8_status", 65'(status), 65'd0);

    // address continuity: 0x0 + 4 words expects 0x20 next
    do_flush();
    push_words(64'h3300_0000_0000_0000, 4, 1'b1);
    send_pkt(mk_hdr(4'h6, 32'h0000_0000), 32'h1, 4, 64'h3300_0000_0000_0000, st);
    push_words(64'h3400_0000_0000_0000, 2, 1'b1);
    send_pkt(mk_hdr(4'h6, 32'h0000_0040), 32'h1, 2, 64'h3400_0000_0000_0000, st);
    wait_drain();
    chk("t9_addr_gap_status", 65'(status), 65'({AE, 3'b000}));
    chk("t9_addr_gap_pkt_cnt", 65'(pkt_cnt), 65'd2);
    do_flush();
    push_words(64'h3500_0000_0000_0000, 4, 1'b1);
    send_pkt(mk_hdr(4'h6, 32'h0000_0000), 32'h1, 4, 64'h3500_0000_0000_0000, st);
    push_words(64'h3600_0000_0000_0000, 2, 1'b1);
    send_pkt(mk_hdr(4'h6, 32'h0000_0020), 32'h1, 2, 64'h3600_0000_0000_0000, st);
    wait_drain();
    chk("t9_addr_seq_status", 65'(status), 65'd0);
    chk("t9_addr_seq_pkt_cnt", 65'(pkt_cnt), 65'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/srio_swrite_unpack_logic.md
# srio_swrite_unpack_logic

Receive-side counterpart of the SWRITE packer: consumes SRIO type-6 (SWRITE) packets from the SRIO endpoint's AXI-Stream user port, checks and strips the 64-bit header, and forwards the payload as a plain 64-bit AXI-Stream toward the DMA/FIFO. Captures address and source/destination IDs per packet and reports sticky error status to the register bank.

## Interface
- MAX_PAYLOAD, 32: maximum payload words (64-bit) per packet.
- AXIS_ACLK  in  1  single clock; all logic rising-edge.
- AXIS_ARESET  in  1  reset, synchronous, active-high.
- S_AXIS_TVALID / S_AXIS_TREADY / S_AXIS_TLAST  in/out/in  1  packet stream from SRIO.
- S_AXIS_TDATA  in  64  header word, then payload.
- S_AXIS_TUSER  in  32  srcdest; sampled on header beat.
- M_AXIS_TVALID / M_AXIS_TREADY / M_AXIS_TLAST  out/in/out  1  payload stream.
- M_AXIS_TDATA  out  64  payload word.
- cmd  in  32  bit0 enable, bit1 flush (level).
- last_addr  out  32  header[31:0] of last accepted packet.
- last_srcdest  out  32  TUSER of last accepted packet.
- pkt_cnt  out  16  good packets forwarded, wraps at 0xFFFF->0.
- status  out  4  sticky: [0] type_err, [1] oversize_err, [2] runt_err, [3] addr_err.

## Operation
- Header layout: [55:52] ftype, [46:45] prio, [44] crf, [31:0] addr; other bits ignored.
- States: IDLE, HDR, PAYLOAD, DROP.
- IDLE: S_AXIS_TREADY=0; to HDR when cmd[0]=1.
- HDR: TREADY=1. On header beat: ftype!=4'b0110 -> type_err, DROP (or stay HDR if TLAST). TLAST on header -> runt_err, stay HDR, nothing emitted. Else capture addr/srcdest, word count=0, -> PAYLOAD.
- PAYLOAD: each accepted beat loads output register; M_AXIS_TLAST = S_AXIS_TLAST or count==MAX_PAYLOAD-1. On final beat: pkt_cnt+1, -> HDR. Word MAX_PAYLOAD-1 without TLAST -> oversize_err, forced M TLAST, -> DROP.
- DROP: TREADY=1, discard until TLAST beat, -> HDR.
- cmd[0] low: finishes current packet, then IDLE from HDR.
- cmd[1] high: state -> IDLE, output register invalidated, count=0, status=0, pkt_cnt=0; held while asserted.
- Count: 6-bit, compare against MAX_PAYLOAD-1.

## Timing
- Reset: state IDLE; M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, S_AXIS_TREADY=0, last_addr=0, last_srcdest=0, pkt_cnt=0, status=0.
- Latency: payload beat accepted at cycle n appears on M_AXIS at n+1.
- PAYLOAD: S_AXIS_TREADY = !M_AXIS_TVALID | M_AXIS_TREADY; full rate, 1 word/clk when downstream ready.
- M_AXIS_TDATA/TLAST stable while TVALID & !TREADY.
- Header costs one S-side cycle; no M-side bubble needed beyond it. Next header can be accepted the cycle after a last payload beat is accepted, while that beat is still in the output register.
- last_addr/last_srcdest update the cycle after the header beat; pkt_cnt updates the cycle after the final input beat.
- Flush and input beat in same cycle: flush wins, beat discarded.

## Configuration
- SRIO_SWRITE_UNPACK_ADDR_CHECK_EN defined: expected address register. Set from the first good header after flush. Advances by 8×payload words at end of each good packet. Header addr mismatch -> addr_err set, packet still forwarded, expected resyncs to new addr.
- Not defined: no expected-address register; status[3] tied 0.

## Structure
- Shared package srio_pkg: FTYPE_SWRITE=4'b0110, header field bit positions, MAX_PAYLOAD default, status bit indices; the packer uses the same package.
- One natural sub-module: axis_out_reg (1-deep output register with ready/valid), instanced once.

## Test plan
- Header addr 0x1000_0000, TUSER 0x0001_0002, 4 payload words with TLAST on word 4 -> 4 words out, M TLAST on 4th; last_addr=0x1000_0000, last_srcdest=0x0001_0002, pkt_cnt=1, status=0.
- Header ftype 0x5, 3 words -> nothing out; status[0]=1; next good packet forwarded normally.
- 40 words after header, TLAST on 40 -> 32 words out, TLAST on 32nd, 8 dropped, status[1]=1, pkt_cnt unchanged.
- Header beat with TLAST -> no output, status[2]=1, state returns to HDR.
- Random M_AXIS_TREADY (50%) on 32-word packet -> all 32 words in order, none duplicated; full rate with TREADY=1.
- Flush mid-packet after 10 words -> TVALID=0 next cycle, status=0, pkt_cnt=0. Re-enable; new packet addr 0x2000 -> correct output. With ADDR_CHECK_EN: packets addr 0x0 (4 words) then 0x40 -> addr_err=1; packets 0x0 then 0x20 -> addr_err=0.
